// File: rtl/mac_pkg.sv
// Shared types and widths for the multiply-accumulate operand feeder.
package mac_pkg;
  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mac_acc_stage.sv
// Product capture register followed by the wide accumulator with carry-out
// and sticky overflow.
module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_p_valid,
  input  logic [PROD_W-1:0] i_p,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf,
  output logic              o_pipe_busy
);

  logic [PROD_W-1:0] r_p;
  logic              r_p_valid;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [ACC_W:0]    w_sum;

  assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_p};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p       <= '0;
      r_p_valid <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_p_valid <= i_p_valid;
      if (i_p_valid) r_p <= i_p;
      if (i_clear) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_p_valid) begin
        // Wraps modulo 2^ACC_W; the lost carry is remembered in the flag.
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end
    end
  end

  assign o_acc       = r_acc;
  assign o_ovf       = r_ovf;
  assign o_pipe_busy = r_p_valid;

endmodule

// File: rtl/mac_accum_ctrl.sv
// Burst operand feeder for an external combinational multiplier; sums the
// products of one burst and hands the total out over valid/ready.
module mac_accum_ctrl
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [OP_W-1:0]   i_in_a,
  input  logic [OP_W-1:0]   i_in_b,
  output logic [OP_W-1:0]   o_mult_x,
  output logic [OP_W-1:0]   o_mult_y,
  input  logic [PROD_W-1:0] i_mult_p,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_acc,
  output logic              o_out_ovf,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_remaining;
  logic             r_s1_valid;
  logic [OP_W-1:0]  r_mult_x;
  logic [OP_W-1:0]  r_mult_y;
  logic             w_beat;
  logic             w_clear;
  logic             w_load;
  logic             w_pipe_busy;

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    w_beat       = 1'b0;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clear = 1'b1;
          if (i_len != '0) begin
            w_load       = 1'b1;
            w_state_next = S_RUN;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_RUN: begin
        o_in_ready = 1'b1;
        w_beat     = i_in_valid;
        if (w_beat && r_remaining == CNT_ONE) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Once stage 1 is empty, stage 2 empties on this same edge, so the
        // accumulator is final when DONE is entered.
        if (!r_s1_valid) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (i_out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_s1_valid  <= 1'b0;
      r_mult_x    <= '0;
      r_mult_y    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_s1_valid <= w_beat;
      if (w_load) begin
        r_remaining <= i_len;
      end else if (w_beat) begin
        r_remaining <= r_remaining - CNT_ONE;
      end
      if (w_beat) begin
        r_mult_x <= i_in_a;
        r_mult_y <= i_in_b;
      end
    end
  end

  mac_acc_stage #(
    .ACC_W (ACC_W)
  ) u_acc_stage (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_p_valid   (r_s1_valid),
    .i_p         (i_mult_p),
    .o_acc       (o_out_acc),
    .o_ovf       (o_out_ovf),
    .o_pipe_busy (w_pipe_busy)
  );

  assign o_mult_x    = r_mult_x;
  assign o_mult_y    = r_mult_y;
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);

  logic w_unused;
  assign w_unused = w_pipe_busy;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Self-checking bench for mac_accum_ctrl: a 40-bit and a 32-bit accumulator
// instance share all stimulus; results are scored against a queue.
module tb_mac_accum_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_len;
  logic        i_in_valid;
  logic [15:0] i_in_a;
  logic [15:0] i_in_b;
  logic        i_out_ready;

  logic        o_in_ready, o_out_valid, o_out_ovf, o_busy;
  logic [15:0] o_mult_x, o_mult_y;
  logic [39:0] o_out_acc;
  logic [31:0] w_mult_p;

  logic        o_in_ready32, o_out_valid32, o_out_ovf32, o_busy32;
  logic [15:0] o_mult_x32, o_mult_y32;
  logic [31:0] o_out_acc32;
  logic [31:0] w_mult_p32;

  always #5 i_clk = ~i_clk;

  assign w_mult_p   = 32'(o_mult_x)   * 32'(o_mult_y);
  assign w_mult_p32 = 32'(o_mult_x32) * 32'(o_mult_y32);

  mac_accum_ctrl #(.ACC_W(40), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_mult_x(o_mult_x), .o_mult_y(o_mult_y), .i_mult_p(w_mult_p),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_acc(o_out_acc), .o_out_ovf(o_out_ovf), .o_busy(o_busy)
  );

  mac_accum_ctrl #(.ACC_W(32), .CNT_W(8)) dut32 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready32),
    .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_mult_x(o_mult_x32), .o_mult_y(o_mult_y32), .i_mult_p(w_mult_p32),
    .o_out_valid(o_out_valid32), .i_out_ready(i_out_ready),
    .o_out_acc(o_out_acc32), .o_out_ovf(o_out_ovf32), .o_busy(o_busy32)
  );

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [15:0]      vpat;
    logic [39:0]      exp_acc;
    logic             exp_ovf;
    logic [7:0]       hold;
  } vec_t;

  typedef struct packed {
    logic [39:0] acc;
    logic        ovf;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len,
                              input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3,
                              input logic [15:0] vp, input logic [39:0] acc,
                              input logic ovf, input int hold);
    vec_t v;
    v.len     = len[7:0];
    v.a       = {a3, a2, a1, a0};
    v.b       = {b3, b2, b1, b0};
    v.vpat    = vp;
    v.exp_acc = acc;
    v.exp_ovf = ovf;
    v.hold    = hold[7:0];
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: pop one expectation per accepted result on either instance.
  always @(negedge i_clk) begin
    if (!i_rst && o_out_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("FAIL unexpected_result: got acc 0x%0h, want no result", o_out_acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_acc40", 64'(o_out_acc), 64'(e.acc));
        check("sb_ovf40", 64'(o_out_ovf), 64'(e.ovf));
        check("sb_valid32", 64'(o_out_valid32), 64'd1);
        check("sb_acc32", 64'(o_out_acc32), 64'(e.acc[31:0]));
        check("sb_ovf32", 64'(o_out_ovf32), 64'(e.acc[39:32] != 8'd0));
      end
    end
  end

  task automatic run_burst(input int idx);
    vec_t v;
    int   k;
    int   cyc;
    v = vecs[idx];
    i_out_ready = 1'b0;
    i_start     = 1'b1;
    i_len       = v.len;
    step();
    i_start = 1'b0;
    check("run_busy", 64'(o_busy), 64'd1);
    sb.push_back('{acc: v.exp_acc, ovf: v.exp_ovf});
    k   = 0;
    cyc = 0;
    while (k < int'(v.len) && cyc < 16) begin
      check("in_ready_run", 64'(o_in_ready), 64'd1);
      i_in_valid = v.vpat[cyc];
      i_in_a     = v.a[k];
      i_in_b     = v.b[k];
      step();
      if (v.vpat[cyc]) k++;
      cyc++;
    end
    i_in_valid = 1'b0;
    check("beats_done", 64'(k), 64'(v.len));
    // Now one cycle after the final beat.
    check("lat_t1_valid", 64'(o_out_valid), 64'd0);
    check("lat_t1_ready", 64'(o_in_ready), 64'd0);
    step();
    check("lat_t2_valid", 64'(o_out_valid), 64'd0);
    step();
    check("lat_t3_valid", 64'(o_out_valid), 64'd1);
    for (int h = 0; h < int'(v.hold); h++) begin
      step();
      check("hold_valid", 64'(o_out_valid), 64'd1);
      check("hold_acc", 64'(o_out_acc), 64'(v.exp_acc));
    end
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    check("post_valid", 64'(o_out_valid), 64'd0);
    check("post_busy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(3, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd0, 16'd0,
                 16'hFFFF, 40'd98, 1'b0, 5);
    vecs[1] = mk(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0,
                 16'hFFFF, 40'h1_FFFC_0002, 1'b0, 0);
    vecs[2] = mk(3, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd0, 16'd0,
                 16'h0029, 40'd14, 1'b0, 0);
    vecs[3] = mk(4, 16'd100, 16'd200, 16'd300, 16'd400, 16'd1000, 16'd1000, 16'd65535, 16'd2,
                 16'hFFFF, 40'd1271070, 1'b0, 1);
    vecs[4] = mk(1, 16'd10, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                 16'hFFFF, 40'd200, 1'b0, 0);

    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_in_valid = 1'b0;
    i_in_a = '0; i_in_b = '0; i_out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 64'(o_out_valid), 64'd0);
    check("rst_acc", 64'(o_out_acc), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_in_ready", 64'(o_in_ready), 64'd0);
    check("rst_mult_x", 64'(o_mult_x), 64'd0);
    i_rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_burst(i);

    // Zero length, then a start during DONE must be ignored.
    i_start = 1'b1; i_len = 8'd0;
    sb.push_back('{acc: 40'd0, ovf: 1'b0});
    step();
    i_start = 1'b1; i_len = 8'd3;
    check("zl_valid", 64'(o_out_valid), 64'd1);
    check("zl_acc", 64'(o_out_acc), 64'd0);
    step();
    i_start = 1'b0;
    check("zl_ign_valid", 64'(o_out_valid), 64'd1);
    check("zl_ign_busy", 64'(o_busy), 64'd1);
    check("zl_ign_ready", 64'(o_in_ready), 64'd0);
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    check("zl_idle_busy", 64'(o_busy), 64'd0);

    // Reset after two of four beats.
    i_start = 1'b1; i_len = 8'd4;
    step();
    i_start = 1'b0;
    i_in_valid = 1'b1; i_in_a = 16'd500; i_in_b = 16'd600;
    step();
    i_in_a = 16'd700; i_in_b = 16'd800;
    step();
    i_rst = 1'b1; i_in_valid = 1'b0;
    step();
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_valid", 64'(o_out_valid), 64'd0);
    check("mid_rst_acc", 64'(o_out_acc), 64'd0);
    check("mid_rst_ovf", 64'(o_out_ovf), 64'd0);
    check("mid_rst_ready", 64'(o_in_ready), 64'd0);
    check("mid_rst_mult", 64'({o_mult_x, o_mult_y}), 64'd0);
    i_rst = 1'b0;
    step();
    run_burst(4);

    step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/mac_accum_ctrl.md
Name: mac_accum_ctrl

Overview:
- Sequential operand feeder and product accumulator built around the team's combinational 16x16 unsigned Booth/Wallace multiplier.
- Accepts a burst of LEN operand pairs over a valid/ready handshake and registers each pair onto the multiplier inputs.
- Captures the 32-bit product one cycle later, sums all LEN products into a wide accumulator, and presents the result on a valid/ready output.
- Sits between the operand source and the result consumer; the multiplier instance lives at the parent level.

Parameters:
- ACC_W, 40, accumulator/result width (must be >= 32).
- CNT_W, 8, width of burst length and beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin burst; sampled only in IDLE.
- len  in  CNT_W  number of operand pairs in the burst; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operand pair.
- in_a  in  16  operand A (unsigned).
- in_b  in  16  operand B (unsigned).
- mult_x  out  16  registered operand to multiplier X.
- mult_y  out  16  registered operand to multiplier Y.
- mult_p  in  32  multiplier product (combinational from mult_x/mult_y).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_acc  out  ACC_W  accumulated sum.
- out_ovf  out  1  sticky accumulator overflow.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs are 0; state is IDLE; pipeline valids, counter, accumulator and ovf are cleared. Reset mid-burst aborts immediately with no output, and operands already in flight are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with len>0: clear acc and ovf, load remaining=len, go to RUN.
  - start=1 with len=0: clear acc, go to DONE, so out_valid=1 on the next cycle.
- RUN:
  - in_ready=1. A beat occurs when in_valid & in_ready.
  - On a beat: mult_x<=in_a, mult_y<=in_b, s1_valid<=1, remaining decrements.
  - On the final beat (remaining==1), go to DRAIN.
  - Cycles without a beat leave mult_x/mult_y holding their values, with s1_valid=0.
- Pipeline:
  - Stage 2: p_reg<=mult_p when s1_valid, and s2_valid<=s1_valid.
  - Stage 3: when s2_valid, {carry,acc}<=acc+zero-extended p_reg. Accumulation wraps modulo 2^ACC_W, and ovf<=ovf|carry.
- DRAIN:
  - in_ready=0; start is ignored.
  - Go to DONE once s1_valid and s2_valid are both 0 at the clock edge.
  - Latency: the last beat in cycle T gives out_valid=1 in cycle T+3.
- DONE:
  - out_valid=1, with out_acc=acc and out_ovf=ovf held stable while out_ready=0.
  - out_valid & out_ready: go to IDLE and deassert out_valid the next cycle.
  - start is ignored.
- in_ready is 0 in IDLE, DRAIN and DONE. A start pulse outside IDLE has no effect.
- out_acc and out_ovf outside DONE show the internal accumulator and flag; they are qualified only by out_valid.

Decomposition:
- Package mac_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - OP_W=16 and PROD_W=32 constants;
  - the default ACC_W.
- One sub-module, mac_acc_stage, contains the stage-2 product register plus the stage-3 accumulator with carry and sticky overflow (inputs: clk, rst, clear, p_valid, p; outputs: acc, ovf, pipe_busy).
- FSM, counter and operand registers stay in the top module.

Test Plan:
- Basic burst: start, len=3, beats (3,4),(5,6),(7,8) back-to-back → out_acc=98, out_ovf=0, out_valid exactly 3 cycles after the third beat.
- Maximum operands: len=2, both beats (0xFFFF,0xFFFF) → out_acc=0x1_FFFC_0002, ovf=0. With ACC_W=32 the same stimulus gives out_acc=0xFFFC_0002, ovf=1.
- Zero length and ignored start: start with len=0 → out_valid=1 on the next cycle with out_acc=0. Then a start pulse during DONE is ignored (busy stays 1, no state change).
- Handshake stalls:
  - in_valid toggled 1,0,0,1,0,1 for len=3 with pairs (1,1),(2,2),(3,3) → out_acc=14 and in_ready=1 throughout RUN.
  - out_ready held 0 for 5 cycles → out_acc/out_valid stable, then one-cycle accept returns the block to IDLE.
- Reset mid-burst: assert rst after 2 of 4 beats → all outputs 0 next cycle. A following burst len=1 with (10,20) → out_acc=200 (no residue from the aborted burst).
